// File: rtl/reg_mpi_master_if.sv
// Host-side request/response channel of reg_mpi_master.
// Request and response each complete on a valid/ready handshake.
interface reg_mpi_master_if #(
    parameter int CPU_ADDR_WIDTH = 12,
    parameter int CPU_DATA_WIDTH = 32
);
    logic                      req_vld;
    logic                      req_rdy;
    logic                      req_wr;
    logic [CPU_ADDR_WIDTH-1:0] req_addr;
    logic [CPU_DATA_WIDTH-1:0] req_wdata;
    logic                      rsp_vld;
    logic                      rsp_rdy;
    logic [CPU_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/reg_mpi_master.sv
// Bridges host requests onto a strobed register-file bus, one
// transaction at a time, with saturating activity counters.
module reg_mpi_master #(
    parameter int                        CPU_ADDR_WIDTH = 12,
    parameter int                        CPU_DATA_WIDTH = 32,
    parameter int                        RD_LAT         = 2,
    parameter logic [CPU_ADDR_WIDTH-1:0] ADDR_MAX       = 12'h009
) (
    input  logic                      clks,
    input  logic                      reset,
    reg_mpi_master_if.slave           host,
    output logic                      cpu_wr,
    output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
    output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
    output logic                      cpu_rd,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
    output logic [15:0]               sta_wr_cnt,
    output logic [15:0]               sta_rd_cnt,
    output logic [15:0]               sta_err_cnt
);
    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RSP} state_t;

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [CPU_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CPU_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic [15:0]               wr_cnt_q, wr_cnt_d;
    logic [15:0]               rd_cnt_q, rd_cnt_d;
    logic [15:0]               err_cnt_q, err_cnt_d;
    logic                      accept;
    logic                      addr_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign host.req_rdy = (state_q == IDLE) & ~reset;
    assign accept       = host.req_vld & host.req_rdy;
    assign addr_ok      = host.req_addr <= ADDR_MAX;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!addr_ok) begin
                        state_d   = RSP;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else if (host.req_wr) begin
                        state_d = WR;
                        addr_d  = host.req_addr;
                        wdata_d = host.req_wdata;
                    end else begin
                        state_d = RD;
                        addr_d  = host.req_addr;
                    end
                end
            end
            WR: begin
                state_d  = RSP;
                err_d    = 1'b0;
                rdata_d  = '0;
                wr_cnt_d = sat_inc(wr_cnt_q);
            end
            RD: begin
                state_d = RD_WAIT;
                cnt_d   = LAT_LAST;
            end
            RD_WAIT: begin
                // Last wait cycle: registered read data is valid now
                if (cnt_q == 4'd0) begin
                    state_d  = RSP;
                    err_d    = 1'b0;
                    rdata_d  = cpu_data_out;
                    rd_cnt_d = sat_inc(rd_cnt_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RSP: begin
                if (host.rsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cpu_wr         = (state_q == WR);
    assign cpu_rd         = (state_q == RD);
    assign cpu_wr_addr    = addr_q;
    assign cpu_data_in    = wdata_q;
    assign host.rsp_vld   = (state_q == RSP);
    assign host.rsp_rdata = rdata_q;
    assign host.rsp_err   = err_q;
    assign sta_wr_cnt     = wr_cnt_q;
    assign sta_rd_cnt     = rd_cnt_q;
    assign sta_err_cnt    = err_cnt_q;
endmodule

// File: doc/reg_mpi_master.md
REG_MPI_MASTER -- requirements
Module: reg_mpi_master

Interface
REQ-001 Parameter CPU_ADDR_WIDTH, 12, register address width.
REQ-002 Parameter CPU_DATA_WIDTH, 32, register data width.
REQ-003 Parameter RD_LAT, 2, cycles from cpu_rd strobe to sample of cpu_data_out; legal 1..15.
REQ-004 Parameter ADDR_MAX, 12'h009, highest implemented register address.
REQ-005 Reset reset, asynchronous, active-high; clock clks.
REQ-006 clks  in  1  clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 req_vld  in  1  host request valid.
REQ-009 req_rdy  out  1  block can accept a request.
REQ-010 req_wr  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  CPU_ADDR_WIDTH  register address.
REQ-012 req_wdata  in  CPU_DATA_WIDTH  write data.
REQ-013 rsp_vld  out  1  response valid.
REQ-014 rsp_rdy  in  1  host accepts response.
REQ-015 rsp_rdata  out  CPU_DATA_WIDTH  read data; 0 for writes and errors.
REQ-016 rsp_err  out  1  address above ADDR_MAX.
REQ-017 cpu_wr  out  1  register-file write strobe.
REQ-018 cpu_wr_addr  out  CPU_ADDR_WIDTH  shared read/write address.
REQ-019 cpu_data_in  out  CPU_DATA_WIDTH  write data to register file.
REQ-020 cpu_rd  out  1  register-file read strobe.
REQ-021 cpu_data_out  in  CPU_DATA_WIDTH  registered read data from register file.
REQ-022 sta_wr_cnt, sta_rd_cnt, sta_err_cnt  out  16 each  issued writes, issued reads, rejected requests.

Function
REQ-023 FSM states: IDLE, WR, RD, RD_WAIT, RSP; only IDLE asserts req_rdy.
REQ-024 Accept on edge where req_vld & req_rdy; latch req_wr, req_addr, req_wdata; req_vld outside IDLE is ignored.
REQ-025 Accepted address > ADDR_MAX: IDLE -> RSP directly, no cpu_wr/cpu_rd pulse, rsp_err=1, rsp_rdata=0, sta_err_cnt+1.
REQ-026 Valid write: IDLE -> WR; in WR cpu_wr=1 for exactly one cycle with cpu_wr_addr/cpu_data_in = latched values; WR -> RSP; rsp_err=0, rsp_rdata=0; sta_wr_cnt+1.
REQ-027 Valid read: IDLE -> RD; in RD (cycle T) cpu_rd=1 for exactly one cycle, cpu_wr_addr = latched address; RD -> RD_WAIT.
REQ-028 RD_WAIT lasts RD_LAT cycles (4-bit down-counter); cpu_data_out captured on edge ending cycle T+RD_LAT into rsp_rdata; -> RSP; sta_rd_cnt+1.
REQ-029 cpu_wr_addr held constant from strobe cycle through capture edge; between transactions holds last value.
REQ-030 cpu_data_in holds last written value when not writing.
REQ-031 RSP: rsp_vld=1, rsp_rdata/rsp_err stable until rsp_vld & rsp_rdy; then -> IDLE; next accept earliest one cycle later.
REQ-032 Latency with rsp_rdy=1: write accept edge N -> cpu_wr in cycle N+1 -> rsp_vld in N+2; read accept N -> cpu_rd in N+1 -> rsp_vld in N+2+RD_LAT; error rsp_vld in N+1.
REQ-033 cpu_wr and cpu_rd never both high; at most one bus transaction outstanding.
REQ-034 Status counters saturate at 16'hFFFF, never wrap.

Reset
REQ-035 On reset all outputs 0 except req_rdy=0 during reset, 1 in first IDLE cycle after release; FSM -> IDLE; counters 0.
REQ-036 Reset mid-transaction aborts immediately: strobes low same cycle, pending response discarded, no counter update.

Verification
REQ-037 Write addr 0x002 data 0x0000_0005, rsp_rdy=1 -> single cpu_wr pulse addr 0x002 data 0x5, rsp_vld 2 cycles after accept, rsp_err=0, sta_wr_cnt=1.
REQ-038 Read addr 0x000, responder model returns 0x2018_0308 one cycle after address, RD_LAT=2 -> single cpu_rd pulse, rsp_rdata=0x2018_0308, rsp_vld 4 cycles after accept.
REQ-039 Read addr 0x00A -> no strobe, rsp_err=1, rsp_rdata=0, sta_err_cnt=1, rsp_vld 1 cycle after accept.
REQ-040 rsp_rdy held 0 for 5 cycles with req_vld=1 -> rsp_vld/data stable, req_rdy=0, no new strobes; release -> next request accepted one cycle after handshake.
REQ-041 Reset asserted in RD_WAIT -> cpu_rd/rsp_vld low, counters 0, first post-reset request completes normally.
REQ-042 Preload sta_wr_cnt to 0xFFFF via 65535 writes (or force) then one more write -> stays 0xFFFF.
